// File: rtl/muxarb_pkg.sv
// Shared definitions for the L2 2-to-1 byte mux arbiter.
// Contents:
//   DEF_DATA_W  - default lane/output data width
//   CNT_W       - width of the optional grant counters
//   out_state_e - output stage FSM encoding
//   LANE0/LANE1 - lane index constants
//   rr_pick     - round-robin lane choice when both lanes are pending
package muxarb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int CNT_W      = 16;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_e;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    // With both lanes pending, the lane that did not win last time goes next.
    function automatic logic rr_pick(input logic last_grant);
        return (last_grant == LANE0) ? LANE1 : LANE0;
    endfunction

endpackage

// File: rtl/muxarb_lane_fifo.sv
// Per-lane synchronous FIFO.
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-high reset; discards all contents
//   push_i   - write data_i (ignored when full)
//   data_i   - write data
//   pop_i    - drop the head entry (ignored when empty)
//   head_o   - current head entry (valid when !empty_o)
//   full_o   - count_o == DEPTH
//   empty_o  - count_o == 0
//   count_o  - occupancy, log2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
module muxarb_lane_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CW-1:0]     count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mux_arbiter_2to1.sv
// Round-robin arbiter and registered output stage for the L2 2-to-1 byte mux.
// Two lanes push bytes into per-lane FIFOs; one lane per cycle is granted into
// an output register that holds until the downstream stage accepts it.
//
// Optional feature: define MUXARB_STATS_EN to add saturating per-lane grant
// counters (grant_cnt0/grant_cnt1 ports).
//
// Ports:
//   clk_4f          - sole clock, rising edge
//   reset           - synchronous, active-high
//   in0/valid_bit0  - lane 0 data/valid;   ready0 - lane 0 can accept
//   in1/valid_bit1  - lane 1 data/valid;   ready1 - lane 1 can accept
//   out_ready       - downstream accepts data_out1
//   selector        - lane of the byte in the output stage
//   data_out1       - registered output byte
//   valid_bit_out1  - data_out1 valid
//   grant_cnt0/1    - grant counters (MUXARB_STATS_EN only)
//
// Output FSM:
//   state     | meaning
//   OUT_EMPTY | output register holds no valid byte
//   OUT_VALID | output register holds a byte awaiting out_ready
module mux_arbiter_2to1
    import muxarb_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0,
    input  logic              valid_bit0,
    output logic              ready0,
    input  logic [DATA_W-1:0] in1,
    input  logic              valid_bit1,
    output logic              ready1,
    input  logic              out_ready,
    output logic              selector,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_bit_out1
`ifdef MUXARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              sel_q,   sel_d;
    logic              last_q,  last_d;

    logic [DATA_W-1:0] head0, head1;
    logic              full0, full1;
    logic              empty0, empty1;
    logic [FW-1:0]     count0, count1;
    logic              push0, push1;
    logic              pop0, pop1;
    logic              load_ok;
    logic              grant;
    logic              grant_lane;

    // Readiness is taken from the count; full is implied by it.
    logic unused_full;
    assign unused_full = full0 ^ full1;

    assign ready0 = !reset && (count0 < FW'(FIFO_DEPTH));
    assign ready1 = !reset && (count1 < FW'(FIFO_DEPTH));
    assign push0  = valid_bit0 && ready0;
    assign push1  = valid_bit1 && ready1;

    muxarb_lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo0 (
        .clk_i   (clk_4f),
        .rst_i   (reset),
        .push_i  (push0),
        .data_i  (in0),
        .pop_i   (pop0),
        .head_o  (head0),
        .full_o  (full0),
        .empty_o (empty0),
        .count_o (count0)
    );

    muxarb_lane_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo1 (
        .clk_i   (clk_4f),
        .rst_i   (reset),
        .push_i  (push1),
        .data_i  (in1),
        .pop_i   (pop1),
        .head_o  (head1),
        .full_o  (full1),
        .empty_o (empty1),
        .count_o (count1)
    );

    always_comb begin
        load_ok    = (state_q == OUT_EMPTY) || out_ready;
        grant      = 1'b0;
        grant_lane = LANE0;
        if (load_ok) begin
            if (!empty0 && !empty1) begin
                grant      = 1'b1;
                grant_lane = rr_pick(last_q);
            end else if (!empty0) begin
                grant      = 1'b1;
                grant_lane = LANE0;
            end else if (!empty1) begin
                grant      = 1'b1;
                grant_lane = LANE1;
            end
        end
    end

    assign pop0 = grant && (grant_lane == LANE0);
    assign pop1 = grant && (grant_lane == LANE1);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            OUT_EMPTY: begin
                if (grant) begin
                    state_d = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (out_ready) begin
                    state_d = grant ? OUT_VALID : OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
        if (grant) begin
            data_d = (grant_lane == LANE1) ? head1 : head0;
            sel_d  = grant_lane;
            last_d = grant_lane;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            data_q  <= '0;
            sel_q   <= LANE0;
            last_q  <= LANE1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign valid_bit_out1 = (state_q == OUT_VALID);
    assign data_out1      = data_q;
    assign selector       = sel_q;

`ifdef MUXARB_STATS_EN
    logic [CNT_W-1:0] gcnt0_q, gcnt1_q;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (pop0 && (gcnt0_q != '1)) begin
                gcnt0_q <= gcnt0_q + CNT_W'(1);
            end
            if (pop1 && (gcnt1_q != '1)) begin
                gcnt1_q <= gcnt1_q + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
module tb_mux_arbiter_2to1;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk_4f = 1'b0;
    logic          reset;
    logic [DW-1:0] in0, in1;
    logic          valid_bit0, valid_bit1;
    logic          ready0, ready1;
    logic          out_ready;
    logic          selector;
    logic [DW-1:0] data_out1;
    logic          valid_bit_out1;
`ifdef MUXARB_STATS_EN
    logic [15:0]   grant_cnt0, grant_cnt1;
`endif

    mux_arbiter_2to1 #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_4f         (clk_4f),
        .reset          (reset),
        .in0            (in0),
        .valid_bit0     (valid_bit0),
        .ready0         (ready0),
        .in1            (in1),
        .valid_bit1     (valid_bit1),
        .ready1         (ready1),
        .out_ready      (out_ready),
        .selector       (selector),
        .data_out1      (data_out1),
        .valid_bit_out1 (valid_bit_out1)
`ifdef MUXARB_STATS_EN
        ,
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1)
`endif
    );

    always #5 clk_4f = ~clk_4f;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: lane queues, output register, round-robin memory.
    byte unsigned q0[$];
    byte unsigned q1[$];
    logic [8:0]   expq[$];   // {lane, byte} expected in the output stage
    bit           mvalid = 1'b0;
    byte unsigned mdata  = 8'h00;
    bit           msel   = 1'b0;
    bit           mlast  = 1'b1;
    int           gc0 = 0, gc1 = 0;
    bit           mon_en = 1'b0;

    always @(posedge clk_4f) begin
        if (reset) begin
            q0.delete(); q1.delete(); expq.delete();
            mvalid = 1'b0; mdata = 8'h00; msel = 1'b0; mlast = 1'b1;
            gc0 = 0; gc1 = 0;
            mon_en = 1'b1;
        end else begin
            int  n0, n1;
            bit  p0, p1, load_ok, g, lane;
            byte unsigned b;
            n0 = q0.size();
            n1 = q1.size();
            p0 = valid_bit0 && (n0 < DEPTH);
            p1 = valid_bit1 && (n1 < DEPTH);
            load_ok = !mvalid || out_ready;
            g = 1'b0; lane = 1'b0;
            if (load_ok) begin
                if (n0 > 0 && n1 > 0) begin g = 1'b1; lane = !mlast; end
                else if (n0 > 0)      begin g = 1'b1; lane = 1'b0;   end
                else if (n1 > 0)      begin g = 1'b1; lane = 1'b1;   end
            end
            if (g) begin
                b = lane ? q1.pop_front() : q0.pop_front();
                mdata = b; msel = lane; mlast = lane; mvalid = 1'b1;
                expq.push_back({lane, b});
                if (lane) begin if (gc1 < 65535) gc1++; end
                else      begin if (gc0 < 65535) gc0++; end
            end else if (load_ok) begin
                mvalid = 1'b0;
            end
            if (p0) q0.push_back(in0);
            if (p1) q1.push_back(in1);
        end
    end

    // Monitor: compares DUT against the model away from the active edge and
    // retires scoreboard entries when the downstream accepts them.
    always @(negedge clk_4f) begin
        if (mon_en) begin
            chk("ready0", {31'd0, ready0}, {31'd0, !reset && (q0.size() < DEPTH)});
            chk("ready1", {31'd0, ready1}, {31'd0, !reset && (q1.size() < DEPTH)});
            chk("valid_out", {31'd0, valid_bit_out1}, {31'd0, mvalid});
            if (mvalid) begin
                chk("sb_nonempty", {31'd0, expq.size() != 0}, 32'd1);
                if (expq.size() != 0) begin
                    chk("data_out", {24'd0, data_out1}, {24'd0, expq[0][7:0]});
                    chk("selector", {31'd0, selector}, {31'd0, expq[0][8]});
                    if (out_ready && !reset) void'(expq.pop_front());
                end
            end else begin
                chk("data_hold", {24'd0, data_out1}, {24'd0, mdata});
                chk("sel_hold", {31'd0, selector}, {31'd0, msel});
            end
`ifdef MUXARB_STATS_EN
            chk("grant_cnt0", {16'd0, grant_cnt0}, gc0);
            chk("grant_cnt1", {16'd0, grant_cnt1}, gc1);
`endif
        end
    end

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic drive(input bit v0, input byte unsigned d0,
                         input bit v1, input byte unsigned d1, input bit ordy);
        valid_bit0 = v0; in0 = d0;
        valid_bit1 = v1; in1 = d1;
        out_ready  = ordy;
        step();
    endtask

    initial begin
        reset = 1'b1; valid_bit0 = 0; valid_bit1 = 0; in0 = 0; in1 = 0; out_ready = 1;
        step(); step();
        reset = 1'b0;
        repeat (3) drive(0, 0, 0, 0, 1);

        // Single byte on lane 0.
        drive(1, 8'hA5, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 0, 1);

        // Three bytes on each lane together: expect strict alternation.
        for (int i = 1; i <= 3; i++) drive(1, 8'(i), 1, 8'(8'h10 + i), 1);
        repeat (8) drive(0, 0, 0, 0, 1);

        // Back-pressure: lane 1 fills while the output stalls.
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'(8'h40 + i), 0);
        repeat (3) drive(0, 0, 0, 0, 0);
        repeat (8) drive(0, 0, 0, 0, 1);

        // Fill both lanes, then reset in the middle of draining.
        for (int i = 0; i < 4; i++) drive(1, 8'(8'h60 + i), 1, 8'(8'h70 + i), 0);
        repeat (2) drive(0, 0, 0, 0, 1);
        reset = 1'b1;
        drive(1, 8'hEE, 1, 8'hEF, 1);
        reset = 1'b0;
        repeat (6) drive(0, 0, 0, 0, 1);

        // Randomised traffic with varying pressure and the odd reset.
        for (int i = 0; i < 3000; i++) begin
            int pv, pr;
            pv = (i < 1500) ? 60 : 90;
            pr = (i % 1000 < 500) ? 80 : 30;
            reset = ($urandom_range(599) == 0);
            drive($urandom_range(99) < pv, 8'($urandom),
                  $urandom_range(99) < pv, 8'($urandom),
                  $urandom_range(99) < pr);
        end
        reset = 1'b0;
        repeat (20) drive(0, 0, 0, 0, 1);

        chk("final_drained", {31'd0, valid_bit_out1}, 32'd0);
        chk("final_sb_empty", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mux_arbiter_2to1.md
# mux_arbiter_2to1

Round-robin arbiter and sequencer for the L2 2-to-1 byte mux stage. Two upstream lanes (in0/in1) push bytes into per-lane FIFOs with ready/valid back-pressure. The arbiter grants one lane per cycle, drives `selector`, and presents the chosen byte on a registered output stage held until the downstream stage accepts it. It sits between the L1 lane sources and the L2 mux output on the `clk_4f` domain.

## Interface
- `DATA_W`, 8: lane and output data width.
- `FIFO_DEPTH`, 4: entries per lane FIFO; power of two, ≥2.
- `clk_4f  input  1`: sole clock, rising edge.
- `reset  input  1`: synchronous, active-high. Single clock `clk_4f`; reset synchronous and active-high.
- `in0  input  DATA_W`: lane 0 data.
- `valid_bit0  input  1`: lane 0 valid.
- `ready0  output  1`: lane 0 can accept.
- `in1  input  DATA_W`: lane 1 data.
- `valid_bit1  input  1`: lane 1 valid.
- `ready1  output  1`: lane 1 can accept.
- `out_ready  input  1`: downstream accepts `data_out1`.
- `selector  output  1`: lane of the byte currently in the output stage.
- `data_out1  output  DATA_W`: registered output byte.
- `valid_bit_out1  output  1`: `data_out1` valid.
- `grant_cnt0`, `grant_cnt1  output  16`: grant counters. Present only with `MUXARB_STATS_EN`.

## Operation
- Push: lane N is written when `valid_bit_N && ready_N` at a rising edge.
- `ready_N = !reset && count_N < FIFO_DEPTH`. Combinational from the count; no pass-through when full.
- Output stage can load this cycle (`load_ok`) when `!valid_bit_out1 || out_ready`.
- Grant, only when `load_ok`:
  - Only one FIFO non-empty: grant that lane.
  - Both non-empty: grant the lane ≠ `last_grant`.
  - Neither non-empty: no grant.
- On grant N:
  - Pop FIFO N.
  - `data_out1 <= head_N`, `selector <= N`, `valid_bit_out1 <= 1`, `last_grant <= N`.
- `load_ok` and no grant: `valid_bit_out1 <= 0`; `data_out1` and `selector` hold.
- `!load_ok` (stall): output stage, `selector`, and FIFOs hold (apart from pushes).
- Output FSM, two states:
  - OUT_EMPTY: go to OUT_VALID on grant.
  - OUT_VALID, `out_ready=1`: go to OUT_VALID on grant, otherwise OUT_EMPTY.
  - OUT_VALID, `out_ready=0`: stay in OUT_VALID.
- A push and a pop on the same lane in the same cycle: count unchanged, data ordering preserved.
- FIFO pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth. `count_N` is `log2(FIFO_DEPTH)+1` bits.

## Timing
- Reset values:
  - `data_out1=0`, `valid_bit_out1=0`, `selector=0`.
  - `ready0=ready1=0` while reset is high; 1 on the first cycle after reset.
  - All counts and pointers 0; `last_grant=1`, so lane 0 wins the first tie.
  - Grant counters 0.
- Reset asserted mid-operation: FIFO contents and any in-flight output are discarded at that edge. No push occurs while reset is high.
- Latency: a byte pushed at edge t appears with `valid_bit_out1=1` after edge t+1 when the output stage is free (2 cycles from input-valid cycle to output-valid cycle).
- Throughput: 1 byte/cycle when `out_ready` is held high. Strict alternation when both lanes stay non-empty.
- Stall: `data_out1`/`selector` stable while `valid_bit_out1 && !out_ready`.

## Configuration
- `MUXARB_STATS_EN` defined:
  - `grant_cnt0`/`grant_cnt1` ports exist.
  - Each increments by 1 on a grant to its lane.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: ports and counter logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `muxarb_pkg`:
  - `DATA_W` default and `CNT_W=16`.
  - Output FSM state encoding (OUT_EMPTY=1'b0, OUT_VALID=1'b1).
  - Lane index constants LANE0/LANE1.
- Sub-module `muxarb_lane_fifo`: synchronous FIFO with push/pop, `full`, `empty`, `count`, head data. Instantiated twice.
- Arbitration, output register and counters live in the top module.

## Test plan
- Reset, then idle → `ready0=ready1=1`, `valid_bit_out1=0`, `data_out1=8'h00`, `selector=0`.
- Push 8'hA5 on lane 0 only, `out_ready=1` → two cycles later `data_out1=8'hA5`, `selector=0`, `valid_bit_out1=1`; next cycle `valid_bit_out1=0`.
- Push lane0 {01,02,03} and lane1 {11,12,13} together, `out_ready=1` → output sequence 01,11,02,12,03,13 with `selector` alternating 0,1,…
- `out_ready=0`, push 5 bytes into lane 1 (depth 4) → `ready1` drops after the 4th entry, and the output holds the first byte. Raise `out_ready` → the remaining bytes drain in order.
- Fill both lanes, assert reset for 1 cycle mid-drain → next cycle `valid_bit_out1=0`, both readies 1, and no stale byte is output afterwards.
- `MUXARB_STATS_EN`: 3 grants lane 0, 2 grants lane 1 → `grant_cnt0=3`, `grant_cnt1=2`; force 70000 lane-0 grants → `grant_cnt0=16'hFFFF`.
